// File: rtl/noc_pkg.sv
// noc_pkg: flit type codes, FSM states, head-flit field layout and builder shared by the packetizer.
package noc_pkg;
   localparam logic [1:0] FT_HEAD = 2'b01;
   localparam logic [1:0] FT_BODY = 2'b00;
   localparam logic [1:0] FT_TAIL = 2'b10;
   localparam int SEQ_W = 8;
   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;
   // Head layout: type at the top, optional seq just below it, then src above dest in the low bits.
   function automatic logic [63:0] make_head(input int dw, input int tw, input int dest_w,
                                             input logic [15:0] dest, input logic [15:0] src,
                                             input logic [7:0] seq, input bit seq_en);
      logic [63:0] m;
      m = (64'd1 << dest_w) - 64'd1;
      return (64'(FT_HEAD) << (dw - tw)) | (seq_en ? 64'(seq) << (dw - tw - SEQ_W) : 64'd0) |
             ((64'(src) & m) << dest_w) | (64'(dest) & m);
   endfunction
endpackage

// File: rtl/noc_packetizer.sv
// noc_packetizer: slices one message into head/body/tail flits for the router's local input port.
// Define SEQ_NUM_EN to stamp an 8-bit per-packet sequence number into the head flit.
module noc_packetizer
   import noc_pkg::*;
#(
   parameter int N = 4,
   parameter int INDEX = 0,
   parameter int DATA_WIDTH = 32,
   parameter int TYPE_WIDTH = 2,
   parameter int FlitPerPacket = 6,
   localparam int DEST_W = $clog2(N),
   localparam int PW = DATA_WIDTH - TYPE_WIDTH,
   localparam int PLW = (FlitPerPacket - 1) * PW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DEST_W-1:0]     msg_dest,
   input  logic [PLW-1:0]        msg_payload,
   input  logic                  msg_valid,
   output logic                  msg_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic                  err_dest,
   output logic [15:0]           pkt_sent
);
   localparam int CW = $clog2(FlitPerPacket);
   state_t state_q, state_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic [PLW-1:0] pay_q, pay_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
   logic [15:0] pkt_q, pkt_d;
   logic [7:0] seq_q;
   logic xfer, accept, bad;
   logic [DATA_WIDTH-1:0] head;
   logic [PW-1:0] chunk;
`ifdef SEQ_NUM_EN
   localparam bit SEQ_EN = 1'b1;
   logic [7:0] seq_d;
   always_comb seq_d = (xfer && state_q == S_HEAD) ? seq_q + 8'd1 : seq_q;
   always_ff @(posedge clk) seq_q <= rst ? 8'd0 : seq_d;
`else
   localparam bit SEQ_EN = 1'b0;
   assign seq_q = 8'd0;
`endif
   assign valid_out = state_q != S_IDLE;
   assign xfer = valid_out && ready_out;
   assign msg_ready = !rst && (state_q == S_IDLE || (state_q == S_TAIL && ready_out));
   assign accept = msg_valid && msg_ready;
   assign bad = 32'(msg_dest) >= N;
   assign head = DATA_WIDTH'(make_head(DATA_WIDTH, TYPE_WIDTH, DEST_W, 16'(dest_q), 16'(INDEX),
                                       seq_q, SEQ_EN));
   // Flit i (i >= 1) carries payload chunk i-1.
   assign chunk = PW'(pay_q >> (PW * (32'(cnt_q) - 1)));
   assign data_out = state_q == S_IDLE ? '0 :
                     state_q == S_HEAD ? head :
                     {state_q == S_TAIL ? TYPE_WIDTH'(FT_TAIL) : TYPE_WIDTH'(FT_BODY), chunk};
   assign err_dest = err_q;
   assign pkt_sent = pkt_q;
   always_comb begin
      state_d = state_q;
      dest_d = dest_q;
      pay_d = pay_q;
      cnt_d = cnt_q;
      pkt_d = pkt_q;
      err_d = 1'b0;
      if (xfer) begin
         cnt_d = cnt_q + 1'b1;
         state_d = state_q == S_TAIL ? S_IDLE :
                   ((state_q == S_HEAD && FlitPerPacket == 2) ||
                    (state_q == S_BODY && 32'(cnt_q) == FlitPerPacket - 2)) ? S_TAIL : S_BODY;
         pkt_d = state_q == S_TAIL ? pkt_q + 16'd1 : pkt_q;
      end
      // A new message taken on the tail cycle overrides the return to IDLE.
      if (accept) begin
         dest_d = msg_dest;
         pay_d = msg_payload;
         err_d = bad;
         cnt_d = '0;
         state_d = bad ? S_IDLE : S_HEAD;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dest_q <= '0;
         pay_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
         pkt_q <= '0;
      end else begin
         state_q <= state_d;
         dest_q <= dest_d;
         pay_q <= pay_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         pkt_q <= pkt_d;
      end
   end
endmodule
